// File: rtl/pin_integrator_if.sv
// Bus bundle between the collision stage and pin_integrator: rack load,
// per-tick velocities in, positions and damped velocities out.
interface pin_integrator_if;
  logic              load_in;
  logic [9:0][10:0]  pins_x_init;
  logic [9:0][9:0]   pins_y_init;
  logic              valid_in;
  logic [9:0][15:0]  pins_vx_in;
  logic [9:0][15:0]  pins_vy_in;
  logic [9:0][10:0]  pins_x;
  logic [9:0][9:0]   pins_y;
  logic [9:0][15:0]  pins_vx_out;
  logic [9:0][15:0]  pins_vy_out;
  logic [9:0]        pins_down;
  logic              busy;
  logic              done;

  modport master (
    output load_in, pins_x_init, pins_y_init, valid_in, pins_vx_in, pins_vy_in,
    input  pins_x, pins_y, pins_vx_out, pins_vy_out, pins_down, busy, done
  );

  modport slave (
    input  load_in, pins_x_init, pins_y_init, valid_in, pins_vx_in, pins_vy_in,
    output pins_x, pins_y, pins_vx_out, pins_vy_out, pins_down, busy, done
  );
endinterface

// File: rtl/pin_integrator.sv
// Per-tick motion stage for ten pins: integrates fixed-point positions one pin
// per cycle, applies rolling friction and retires pins that leave the lane.
module pin_integrator #(
  parameter int FRAC_BITS      = 4,
  parameter int FRICTION_SHIFT = 5,
  parameter int STOP_THRESH    = 2,
  parameter int SCREEN_WIDTH   = 1024,
  parameter int SCREEN_HEIGHT  = 768
) (
  input logic             clk_in,
  input logic             rst_in,
  pin_integrator_if.slave bus
);

  localparam int NUM_PINS = 10;
  localparam int X_W      = 11 + FRAC_BITS;
  localparam int Y_W      = 10 + FRAC_BITS;
  localparam int SUM_W    = 18;
  localparam int V_W      = 16;
  localparam int VM_W     = V_W + 1;

  localparam logic signed [SUM_W-1:0] X_LIM    = SUM_W'(SCREEN_WIDTH << FRAC_BITS);
  localparam logic signed [SUM_W-1:0] Y_LIM    = SUM_W'(SCREEN_HEIGHT << FRAC_BITS);
  localparam logic [X_W-1:0]          X_OFF    = X_W'(SCREEN_WIDTH << FRAC_BITS);
  localparam logic signed [VM_W-1:0]  STOP_MAG = VM_W'(STOP_THRESH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_UPDATE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                state_r;
  logic [3:0]            idx_r;
  logic                  busy_r;
  logic                  done_r;
  logic [NUM_PINS-1:0]   down_r;
  logic [X_W-1:0]        x_q_r      [NUM_PINS];
  logic [Y_W-1:0]        y_q_r      [NUM_PINS];
  logic [V_W-1:0]        vx_lat_r   [NUM_PINS];
  logic [V_W-1:0]        vy_lat_r   [NUM_PINS];
  logic [V_W-1:0]        vx_out_r   [NUM_PINS];
  logic [V_W-1:0]        vy_out_r   [NUM_PINS];

  logic [V_W-1:0]          cur_vx_s;
  logic [V_W-1:0]          cur_vy_s;
  logic signed [SUM_W-1:0] nx_s;
  logic signed [SUM_W-1:0] ny_s;
  logic                    off_s;
  logic [V_W-1:0]          dvx_s;
  logic [V_W-1:0]          dvy_s;

  // Friction: subtract v>>>FRICTION_SHIFT, but snap slow pins to rest so they
  // never creep forever on the truncation residue.
  function automatic logic [V_W-1:0] damp(input logic [V_W-1:0] v);
    logic signed [V_W-1:0]  vs;
    logic signed [VM_W-1:0] mag;
    logic [V_W-1:0]         res;
    vs  = v;
    mag = vs[V_W-1] ? -$signed({vs[V_W-1], vs}) : $signed({vs[V_W-1], vs});
    if (mag <= STOP_MAG) begin
      res = {V_W{1'b0}};
    end else begin
      res = vs - (vs >>> FRICTION_SHIFT);
    end
    return res;
  endfunction

  // Next position / velocity of the pin currently addressed by idx_r.
  always_comb begin
    cur_vx_s = vx_lat_r[idx_r];
    cur_vy_s = vy_lat_r[idx_r];
    nx_s  = $signed({{(SUM_W-X_W){1'b0}}, x_q_r[idx_r]})
          + $signed({{(SUM_W-V_W){cur_vx_s[V_W-1]}}, cur_vx_s});
    ny_s  = $signed({{(SUM_W-Y_W){1'b0}}, y_q_r[idx_r]})
          + $signed({{(SUM_W-V_W){cur_vy_s[V_W-1]}}, cur_vy_s});
    off_s = nx_s[SUM_W-1] | ny_s[SUM_W-1] | (nx_s >= X_LIM) | (ny_s >= Y_LIM);
    dvx_s = damp(cur_vx_s);
    dvy_s = damp(cur_vy_s);
  end

  // Control FSM and per-pin state; load overrides any update in flight.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r <= S_IDLE;
      idx_r   <= 4'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      down_r  <= {NUM_PINS{1'b1}};
      for (int i = 0; i < NUM_PINS; i++) begin
        x_q_r[i]    <= X_OFF;
        y_q_r[i]    <= {Y_W{1'b0}};
        vx_lat_r[i] <= {V_W{1'b0}};
        vy_lat_r[i] <= {V_W{1'b0}};
        vx_out_r[i] <= {V_W{1'b0}};
        vy_out_r[i] <= {V_W{1'b0}};
      end
    end else if (bus.load_in) begin
      state_r <= S_IDLE;
      idx_r   <= 4'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      down_r  <= {NUM_PINS{1'b0}};
      for (int i = 0; i < NUM_PINS; i++) begin
        x_q_r[i]    <= {bus.pins_x_init[i], {FRAC_BITS{1'b0}}};
        y_q_r[i]    <= {bus.pins_y_init[i], {FRAC_BITS{1'b0}}};
        vx_lat_r[i] <= {V_W{1'b0}};
        vy_lat_r[i] <= {V_W{1'b0}};
        vx_out_r[i] <= {V_W{1'b0}};
        vy_out_r[i] <= {V_W{1'b0}};
      end
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          done_r <= 1'b0;
          if (bus.valid_in) begin
            for (int i = 0; i < NUM_PINS; i++) begin
              vx_lat_r[i] <= bus.pins_vx_in[i];
              vy_lat_r[i] <= bus.pins_vy_in[i];
            end
            idx_r   <= 4'd0;
            busy_r  <= 1'b1;
            state_r <= S_UPDATE;
          end else begin
            busy_r  <= 1'b0;
            state_r <= S_IDLE;
          end
        end
        S_UPDATE: begin
          if (!down_r[idx_r]) begin
            if (off_s) begin
              down_r[idx_r]   <= 1'b1;
              x_q_r[idx_r]    <= X_OFF;
              y_q_r[idx_r]    <= {Y_W{1'b0}};
              vx_out_r[idx_r] <= {V_W{1'b0}};
              vy_out_r[idx_r] <= {V_W{1'b0}};
            end else begin
              x_q_r[idx_r]    <= nx_s[X_W-1:0];
              y_q_r[idx_r]    <= ny_s[Y_W-1:0];
              vx_out_r[idx_r] <= dvx_s;
              vy_out_r[idx_r] <= dvy_s;
            end
          end else begin
            down_r[idx_r] <= 1'b1;
          end
          if (idx_r == 4'd9) begin
            idx_r   <= 4'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= S_DONE;
          end else begin
            idx_r   <= idx_r + 4'd1;
          end
        end
        default: begin
          idx_r   <= 4'd0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs are straight views of registered state.
  always_comb begin
    for (int i = 0; i < NUM_PINS; i++) begin
      bus.pins_x[i]      = x_q_r[i][X_W-1:FRAC_BITS];
      bus.pins_y[i]      = y_q_r[i][Y_W-1:FRAC_BITS];
      bus.pins_vx_out[i] = vx_out_r[i];
      bus.pins_vy_out[i] = vy_out_r[i];
    end
    bus.pins_down = down_r;
    bus.busy      = busy_r;
    bus.done      = done_r;
  end

endmodule

// File: tb/tb_pin_integrator.sv
// Self-checking bench for pin_integrator: directed vector table, multi-cycle
// handshake/load/reset sequences and randomized ticks against a pin model.
module tb_pin_integrator;
  logic clk = 1'b0;
  logic rst;

  pin_integrator_if bus_if();

  pin_integrator dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model state in subpixels; x=16384 means off-lane.
  int mx[10], my[10], mvx[10], mvy[10];
  bit mdown[10];
  int ix[10], iy[10];
  int tvx[10], tvy[10];

  typedef struct {
    int pin;
    int x0;  int y0;
    int vx;  int vy;
    int ex;  int ey;
    int evx; int evy;
    int edown;
  } vec_t;
  vec_t vecs[9];

  function automatic int floor_div32(input int a);
    if (a >= 0) return a / 32;
    return -((-a + 31) / 32);
  endfunction

  function automatic int model_damp(input int v);
    int m;
    m = (v < 0) ? -v : v;
    if (m <= 2) return 0;
    return v - floor_div32(v);
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 10; i++) begin
      mx[i] = 16384; my[i] = 0; mvx[i] = 0; mvy[i] = 0; mdown[i] = 1'b1;
    end
  endtask

  task automatic model_load();
    for (int i = 0; i < 10; i++) begin
      mx[i] = ix[i] * 16; my[i] = iy[i] * 16; mvx[i] = 0; mvy[i] = 0; mdown[i] = 1'b0;
    end
  endtask

  task automatic model_tick();
    int nx, ny;
    for (int i = 0; i < 10; i++) begin
      if (!mdown[i]) begin
        nx = mx[i] + tvx[i];
        ny = my[i] + tvy[i];
        if (nx < 0 || nx >= 1024 * 16 || ny < 0 || ny >= 768 * 16) begin
          mdown[i] = 1'b1; mx[i] = 16384; my[i] = 0; mvx[i] = 0; mvy[i] = 0;
        end else begin
          mx[i] = nx; my[i] = ny;
          mvx[i] = model_damp(tvx[i]);
          mvy[i] = model_damp(tvy[i]);
        end
      end
    end
  endtask

  task automatic check_all(input string name);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("%s_x%0d", name, i),    int'(bus_if.pins_x[i]), mx[i] / 16);
      chk($sformatf("%s_y%0d", name, i),    int'(bus_if.pins_y[i]), my[i] / 16);
      chk($sformatf("%s_vx%0d", name, i),   int'($signed(bus_if.pins_vx_out[i])), mvx[i]);
      chk($sformatf("%s_vy%0d", name, i),   int'($signed(bus_if.pins_vy_out[i])), mvy[i]);
      chk($sformatf("%s_down%0d", name, i), int'(bus_if.pins_down[i]), int'(mdown[i]));
    end
  endtask

  task automatic drive_vel();
    for (int i = 0; i < 10; i++) begin
      bus_if.pins_vx_in[i] = 16'(tvx[i]);
      bus_if.pins_vy_in[i] = 16'(tvy[i]);
    end
  endtask

  task automatic do_load();
    for (int i = 0; i < 10; i++) begin
      bus_if.pins_x_init[i] = 11'(ix[i]);
      bus_if.pins_y_init[i] = 10'(iy[i]);
    end
    bus_if.load_in = 1'b1;
    edge1();
    bus_if.load_in = 1'b0;
    model_load();
  endtask

  task automatic count_done(input int n, output int dc);
    dc = 0;
    for (int c = 0; c < n; c++) begin
      edge1();
      if (bus_if.done) dc++;
    end
  endtask

  // One full tick: valid pulse, bounded wait for done, model compare.
  task automatic run_tick(input string name);
    int n;
    drive_vel();
    bus_if.valid_in = 1'b1;
    edge1();
    bus_if.valid_in = 1'b0;
    chk({name, "_busy_start"}, int'(bus_if.busy), 1);
    n = 0;
    while (!bus_if.done && n < 30) begin
      edge1();
      n++;
    end
    chk({name, "_latency"}, n, 10);
    chk({name, "_busy_at_done"}, int'(bus_if.busy), 0);
    model_tick();
    check_all(name);
  endtask

  task automatic rack_default();
    for (int i = 0; i < 10; i++) begin
      ix[i] = 600; iy[i] = 200; tvx[i] = 0; tvy[i] = 0;
    end
  endtask

  task automatic rand_vel(input int span);
    for (int i = 0; i < 10; i++) begin
      tvx[i] = int'($urandom_range(0, 2 * span)) - span;
      tvy[i] = int'($urandom_range(0, 2 * span)) - span;
      if ($urandom_range(0, 9) == 0) tvx[i] = int'($urandom_range(0, 65535)) - 32768;
    end
  endtask

  initial begin
    int dc, dat, p;
    vecs[0] = '{0, 500, 100,  32, -16,  502,  99,  31, -15, 0};
    vecs[1] = '{1, 300, 300,   2,   0,  300, 300,   0,   0, 0};
    vecs[2] = '{2, 1022, 50,  48,   0, 1024,   0,   0,   0, 1};
    vecs[3] = '{3, 100,   0,   0, -16, 1024,   0,   0,   0, 1};
    vecs[4] = '{4,   0,  10,  -1,   0, 1024,   0,   0,   0, 1};
    vecs[5] = '{5, 1023, 10,  15,   0, 1023,  10,  15,   0, 0};
    vecs[6] = '{6,  10, 767,   0,  16, 1024,   0,   0,   0, 1};
    vecs[7] = '{7, 300, 300,  -3,   3,  299, 300,  -2,   3, 0};
    vecs[8] = '{9, 200, 200,  -2, -32,  199, 198,   0, -31, 0};

    bus_if.load_in = 1'b0;
    bus_if.valid_in = 1'b0;
    rack_default();
    drive_vel();
    for (int i = 0; i < 10; i++) begin
      bus_if.pins_x_init[i] = 11'd0;
      bus_if.pins_y_init[i] = 10'd0;
    end

    // Reset state, then a tick must leave every retired pin untouched.
    rst = 1'b1;
    edge1();
    edge1();
    rst = 1'b0;
    model_reset();
    chk("reset_busy", int'(bus_if.busy), 0);
    chk("reset_done", int'(bus_if.done), 0);
    check_all("reset");
    rand_vel(300);
    run_tick("post_reset");

    // Directed vector table.
    foreach (vecs[k]) begin
      rack_default();
      p = vecs[k].pin;
      ix[p] = vecs[k].x0; iy[p] = vecs[k].y0;
      do_load();
      tvx[p] = vecs[k].vx; tvy[p] = vecs[k].vy;
      run_tick($sformatf("vec%0d", k));
      chk($sformatf("vec%0d_tx", k),    int'(bus_if.pins_x[p]), vecs[k].ex);
      chk($sformatf("vec%0d_ty", k),    int'(bus_if.pins_y[p]), vecs[k].ey);
      chk($sformatf("vec%0d_tvx", k),   int'($signed(bus_if.pins_vx_out[p])), vecs[k].evx);
      chk($sformatf("vec%0d_tvy", k),   int'($signed(bus_if.pins_vy_out[p])), vecs[k].evy);
      chk($sformatf("vec%0d_tdown", k), int'(bus_if.pins_down[p]), vecs[k].edown);
    end

    // Subpixel accumulation over two back-to-back ticks.
    rack_default();
    ix[1] = 300; iy[1] = 300;
    do_load();
    tvx[1] = 8;
    run_tick("accum1");
    chk("accum1_x", int'(bus_if.pins_x[1]), 300);
    run_tick("accum2");
    chk("accum2_x", int'(bus_if.pins_x[1]), 301);

    // Retired pin stays retired; done is a single-cycle pulse.
    rack_default();
    ix[2] = 1022; iy[2] = 50;
    do_load();
    tvx[2] = 48;
    run_tick("offlane1");
    run_tick("offlane2");
    chk("offlane_down", int'(bus_if.pins_down[2]), 1);
    chk("offlane_x", int'(bus_if.pins_x[2]), 1024);
    edge1();
    chk("done_width", int'(bus_if.done), 0);

    // valid_in while busy is dropped; first velocities apply.
    rack_default();
    do_load();
    rand_vel(200);
    drive_vel();
    bus_if.valid_in = 1'b1;
    edge1();
    model_tick();
    dc = 0; dat = -1;
    for (int e = 1; e <= 14; e++) begin
      if (e == 4) begin
        rand_vel(200);
        drive_vel();
        bus_if.valid_in = 1'b1;
      end else begin
        bus_if.valid_in = 1'b0;
      end
      edge1();
      if (bus_if.done) begin dc++; dat = e; end
    end
    bus_if.valid_in = 1'b0;
    chk("hs_done_count", dc, 1);
    chk("hs_done_edge", dat, 10);
    check_all("handshake");

    // load_in mid-update aborts it.
    rack_default();
    do_load();
    rand_vel(200);
    drive_vel();
    bus_if.valid_in = 1'b1;
    edge1();
    bus_if.valid_in = 1'b0;
    repeat (4) edge1();
    for (int i = 0; i < 10; i++) begin
      ix[i] = int'($urandom_range(0, 1023)); iy[i] = int'($urandom_range(0, 767));
    end
    do_load();
    chk("abort_busy", int'(bus_if.busy), 0);
    check_all("load_abort");
    count_done(15, dc);
    chk("abort_no_done", dc, 0);

    // load_in beats a simultaneous valid_in.
    for (int i = 0; i < 10; i++) begin
      ix[i] = int'($urandom_range(0, 1023)); iy[i] = int'($urandom_range(0, 767));
    end
    rand_vel(200);
    drive_vel();
    bus_if.valid_in = 1'b1;
    do_load();
    bus_if.valid_in = 1'b0;
    chk("lv_busy", int'(bus_if.busy), 0);
    count_done(12, dc);
    chk("lv_no_done", dc, 0);
    check_all("load_valid");

    // Reset in the middle of an update.
    bus_if.valid_in = 1'b1;
    edge1();
    bus_if.valid_in = 1'b0;
    repeat (3) edge1();
    rst = 1'b1;
    edge1();
    rst = 1'b0;
    model_reset();
    chk("midrst_busy", int'(bus_if.busy), 0);
    check_all("mid_reset");
    count_done(12, dc);
    chk("midrst_no_done", dc, 0);

    // Randomized racks and velocities against the model.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 10; i++) begin
        ix[i] = int'($urandom_range(0, 1023)); iy[i] = int'($urandom_range(0, 767));
      end
      do_load();
      for (int t = 0; t < 4; t++) begin
        rand_vel(400);
        run_tick($sformatf("rnd%0d_%0d", r, t));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
